// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: opcode values, phase encodings,
// the ALU-operation set and the packed bundle of datapath controls.
package cpu_pkg;

    localparam int unsigned NPHASE_FIXED = 8;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [2:0] PH_0 = 3'd0;
    localparam logic [2:0] PH_1 = 3'd1;
    localparam logic [2:0] PH_2 = 3'd2;
    localparam logic [2:0] PH_3 = 3'd3;
    localparam logic [2:0] PH_4 = 3'd4;
    localparam logic [2:0] PH_5 = 3'd5;
    localparam logic [2:0] PH_6 = 3'd6;
    localparam logic [2:0] PH_7 = 3'd7;

    // Bit order matches the bench's packed control vector, MSB first.
    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_ac;
        logic ld_pc;
        logic wr;
        logic data_e;
    } ctrl_t;

    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_phase_decode.sv
// Combinational decode of phase/opcode/zero into datapath controls.
// All controls are forced low while the loader owns the bus (en=0).
module cpu_phase_decode
    import cpu_pkg::*;
(
    input  logic [2:0] phase,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       en,
    output ctrl_t      ctrl,
    output logic       hlt_dec
);

    logic aluop;

    always_comb begin
        aluop   = is_aluop(opcode);
        hlt_dec = (phase == PH_4) && (opcode == OP_HLT);
        ctrl    = '0;
        case (phase)
            PH_0: begin
                ctrl.sel = 1'b1;
            end
            PH_1: begin
                ctrl.sel = 1'b1;
                ctrl.rd  = 1'b1;
            end
            PH_2, PH_3: begin
                ctrl.sel   = 1'b1;
                ctrl.rd    = 1'b1;
                ctrl.ld_ir = 1'b1;
            end
            PH_4: begin
                ctrl.inc_pc = 1'b1;
            end
            PH_5: begin
                ctrl.rd = aluop;
            end
            PH_6: begin
                ctrl.rd     = aluop;
                ctrl.inc_pc = (opcode == OP_SKZ) && zero;
                ctrl.ld_pc  = (opcode == OP_JMP);
                ctrl.data_e = (opcode == OP_STO);
            end
            default: begin
                ctrl.rd     = aluop;
                ctrl.ld_ac  = aluop;
                ctrl.ld_pc  = (opcode == OP_JMP);
                ctrl.wr     = (opcode == OP_STO);
                ctrl.data_e = (opcode == OP_STO);
            end
        endcase
        if (!en) begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: 8-phase counter, halt latch, single-step handshake
// and program-loader bus arbitration around a combinational phase decoder.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_PARK | phase 0, idle; starts an instruction or grants the loader
// ST_EXEC | instruction in progress, phase advancing 0..7
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned NPHASE = 8
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       run,
    input  logic       step_req,
    output logic       step_ack,
    input  logic       ld_req,
    output logic       ld_gnt,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    localparam logic [0:0] ST_PARK = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;
    localparam logic [2:0] PH_LAST = 3'(NPHASE - 1);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [2:0] phase_nxt;
    logic       halt_q;
    logic       halt_nxt;
    logic       stepped;
    logic       stepped_nxt;
    logic       ack_nxt;
    logic       gnt_nxt;
    logic       start;
    logic       last;
    logic       hlt_now;
    logic       hlt_dec;
    ctrl_t      ctrl;

    cpu_phase_decode u_decode (
        .phase   (phase),
        .opcode  (opcode),
        .zero    (zero),
        .en      (!ld_gnt),
        .ctrl    (ctrl),
        .hlt_dec (hlt_dec)
    );

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        halt_nxt    = halt_q;
        stepped_nxt = stepped;

        // The cycle after an ack still sees step_req high; it is consumed, not a new request.
        start   = (state == ST_PARK) && !halt_q && !ld_gnt && !ld_req &&
                  (run || (step_req && !step_ack));
        last    = (state == ST_EXEC) && (phase == PH_LAST);
        hlt_now = (state == ST_EXEC) && hlt_dec;
        ack_nxt = last && stepped;
        gnt_nxt = ld_req && (ld_gnt || (state == ST_PARK));

        if (state == ST_PARK) begin
            phase_nxt = PH_0;
            if (start) begin
                state_nxt   = ST_EXEC;
                phase_nxt   = PH_1;
                stepped_nxt = !run;
            end
        end else if (hlt_now) begin
            state_nxt = ST_PARK;
            phase_nxt = PH_0;
            halt_nxt  = 1'b1;
        end else if (last) begin
            phase_nxt = PH_0;
            if (run && !ld_req) begin
                stepped_nxt = 1'b0;
            end else begin
                state_nxt = ST_PARK;
            end
        end else begin
            phase_nxt = phase + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state    <= ST_PARK;
            phase    <= PH_0;
            halt_q   <= 1'b0;
            stepped  <= 1'b0;
            step_ack <= 1'b0;
            ld_gnt   <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            halt_q   <= halt_nxt;
            stepped  <= stepped_nxt;
            step_ack <= ack_nxt;
            ld_gnt   <= gnt_nxt;
        end
    end

    always_comb begin
        sel    = ctrl.sel;
        rd     = ctrl.rd;
        ld_ir  = ctrl.ld_ir;
        inc_pc = ctrl.inc_pc;
        ld_ac  = ctrl.ld_ac;
        ld_pc  = ctrl.ld_pc;
        wr     = ctrl.wr;
        data_e = ctrl.data_e;
        halt   = halt_q || hlt_dec;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: hand-computed control vectors per phase,
// free-run, single-step, loader arbitration, halt and reset abort.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic       clock;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       run;
    logic       step_req;
    logic       step_ack;
    logic       ld_req;
    logic       ld_gnt;
    logic       sel, rd, ld_ir, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic       halt;
    logic [2:0] phase;
    logic [7:0] ctrl;

    int vec_cnt;
    int err_cnt;

    // Per-phase expected control bytes {ph7..ph0}, bits {sel,rd,ld_ir,inc_pc,ld_ac,ld_pc,wr,data_e}.
    localparam logic [63:0] EXP_LDA  = 64'h48_40_40_10_E0_E0_C0_80;
    localparam logic [63:0] EXP_STO  = 64'h03_01_00_10_E0_E0_C0_80;
    localparam logic [63:0] EXP_SKZ1 = 64'h00_10_00_10_E0_E0_C0_80;
    localparam logic [63:0] EXP_SKZ0 = 64'h00_00_00_10_E0_E0_C0_80;
    localparam logic [63:0] EXP_JMP  = 64'h04_04_00_10_E0_E0_C0_80;

    cpu_sequencer #(.NPHASE(8)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .zero     (zero),
        .run      (run),
        .step_req (step_req),
        .step_ack (step_ack),
        .ld_req   (ld_req),
        .ld_gnt   (ld_gnt),
        .sel      (sel),
        .rd       (rd),
        .ld_ir    (ld_ir),
        .inc_pc   (inc_pc),
        .ld_ac    (ld_ac),
        .ld_pc    (ld_pc),
        .wr       (wr),
        .data_e   (data_e),
        .halt     (halt),
        .phase    (phase)
    );

    assign ctrl = {sel, rd, ld_ir, inc_pc, ld_ac, ld_pc, wr, data_e};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Single-steps one instruction from park and checks every phase plus the ack handshake.
    task automatic step_instr(input string tag, input logic [63:0] exp);
        step_req = 1'b1;
        for (int p = 0; p < 8; p++) begin
            check_val({tag, "_phase"}, 8'(phase), 8'(p));
            check_val({tag, "_ctrl"}, ctrl, exp[p*8 +: 8]);
            check_val({tag, "_noack"}, 8'(step_ack), 8'd0);
            tick();
        end
        check_val({tag, "_ack"}, 8'(step_ack), 8'd1);
        check_val({tag, "_ack_ph"}, 8'(phase), 8'd0);
        step_req = 1'b0;
        tick();
        check_val({tag, "_ack_low"}, 8'(step_ack), 8'd0);
        tick();
        check_val({tag, "_parked"}, 8'(phase), 8'd0);
        check_val({tag, "_parked_ctrl"}, ctrl, 8'h80);
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        rst_n    = 1'b0;
        opcode   = OP_LDA;
        zero     = 1'b0;
        run      = 1'b0;
        step_req = 1'b0;
        ld_req   = 1'b0;
        tick(2);

        check_val("rst_phase", 8'(phase), 8'd0);
        check_val("rst_halt", 8'(halt), 8'd0);
        check_val("rst_gnt", 8'(ld_gnt), 8'd0);
        check_val("rst_ack", 8'(step_ack), 8'd0);
        check_val("rst_ctrl", ctrl, 8'h80);

        // Free-run LDA: phases repeat back to back with no park cycle.
        rst_n = 1'b1;
        run   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_val("lda_phase", 8'(phase), 8'(i % 8));
            check_val("lda_ctrl", ctrl, EXP_LDA[(i % 8)*8 +: 8]);
            tick();
        end

        // Loader request mid-instruction is deferred to the next park.
        tick(3);
        check_val("ldm_ph3", 8'(phase), 8'd3);
        ld_req = 1'b1;
        tick(4);
        check_val("ldm_ph7", 8'(phase), 8'd7);
        check_val("ldm_ph7_ctrl", ctrl, 8'h48);
        check_val("ldm_ph7_gnt", 8'(ld_gnt), 8'd0);
        tick();
        check_val("ldm_park_ph", 8'(phase), 8'd0);
        check_val("ldm_park_gnt", 8'(ld_gnt), 8'd0);
        check_val("ldm_park_ctrl", ctrl, 8'h80);
        tick();
        check_val("ldm_gnt", 8'(ld_gnt), 8'd1);
        check_val("ldm_gnt_ctrl", ctrl, 8'h00);
        check_val("ldm_gnt_ph", 8'(phase), 8'd0);
        tick();
        check_val("ldm_gnt_hold", 8'(ld_gnt), 8'd1);
        check_val("ldm_hold_ph", 8'(phase), 8'd0);
        ld_req = 1'b0;
        tick();
        check_val("ldm_gnt_fall", 8'(ld_gnt), 8'd0);
        check_val("ldm_fall_ph", 8'(phase), 8'd0);
        tick();
        check_val("ldm_resume", 8'(phase), 8'd1);

        // Dropping run mid-instruction completes it, then parks.
        run = 1'b0;
        tick(6);
        check_val("norun_ph7", 8'(phase), 8'd7);
        tick(2);
        check_val("norun_park", 8'(phase), 8'd0);

        opcode = OP_STO;
        step_instr("sto", EXP_STO);
        opcode = OP_SKZ;
        zero   = 1'b1;
        step_instr("skz1", EXP_SKZ1);
        zero   = 1'b0;
        step_instr("skz0", EXP_SKZ0);
        opcode = OP_JMP;
        step_instr("jmp", EXP_JMP);

        // Loader and step requested together at park: loader first, step stays pending.
        opcode   = OP_ADD;
        step_req = 1'b1;
        ld_req   = 1'b1;
        tick();
        check_val("both_gnt", 8'(ld_gnt), 8'd1);
        check_val("both_ph", 8'(phase), 8'd0);
        ld_req = 1'b0;
        tick();
        check_val("both_gnt_fall", 8'(ld_gnt), 8'd0);
        check_val("both_ph_wait", 8'(phase), 8'd0);
        tick();
        check_val("both_step_start", 8'(phase), 8'd1);
        tick(6);
        check_val("both_ph7_ctrl", ctrl, 8'h48);
        tick();
        check_val("both_ack", 8'(step_ack), 8'd1);
        step_req = 1'b0;
        tick(2);
        check_val("both_parked", 8'(phase), 8'd0);

        // HLT: halt decoded at phase 4, then latched and parked.
        opcode = OP_HLT;
        run    = 1'b1;
        check_val("hlt_pre", 8'(halt), 8'd0);
        tick(4);
        check_val("hlt_ph4", 8'(phase), 8'd4);
        check_val("hlt_dec", 8'(halt), 8'd1);
        check_val("hlt_ph4_ctrl", ctrl, 8'h10);
        tick();
        check_val("hlt_latch_ph", 8'(phase), 8'd0);
        check_val("hlt_latch", 8'(halt), 8'd1);
        opcode = OP_LDA;
        tick(20);
        check_val("hlt_stuck_ph", 8'(phase), 8'd0);
        check_val("hlt_stuck", 8'(halt), 8'd1);
        ld_req = 1'b1;
        tick();
        check_val("hlt_gnt", 8'(ld_gnt), 8'd1);
        check_val("hlt_gnt_ctrl", ctrl, 8'h00);
        ld_req = 1'b0;
        tick();
        check_val("hlt_gnt_fall", 8'(ld_gnt), 8'd0);
        rst_n = 1'b0;
        tick();
        check_val("hlt_rst", 8'(halt), 8'd0);

        // Reset at phase 7 of STO aborts with no lingering write.
        rst_n  = 1'b1;
        opcode = OP_STO;
        tick(7);
        check_val("rst7_ph", 8'(phase), 8'd7);
        check_val("rst7_wr", ctrl, 8'h03);
        rst_n = 1'b0;
        tick();
        check_val("rst7_after_wr", 8'(wr), 8'd0);
        check_val("rst7_after_ph", 8'(phase), 8'd0);
        check_val("rst7_after_halt", 8'(halt), 8'd0);
        check_val("rst7_after_ctrl", ctrl, 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
